// File: rtl/tlk2711_pkg.sv
// Shared types and 8b/10b symbol constants
// for the TLK2711 transmit framer.
package tlk2711_pkg;

  typedef enum logic [1:0] {
    MODE_NORM  = 2'd0,
    MODE_LOOP  = 2'd1,
    MODE_KCODE = 2'd2,
    MODE_PRBS  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SOF,
    ST_DATA,
    ST_EOF,
    ST_LOOP,
    ST_KCODE,
    ST_PRBS
  } state_e;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D11_5 = 8'hAB;
  localparam logic [7:0] D21_4 = 8'h95;

  localparam logic [15:0] COMMA_W = {K28_5, D5_6};
  localparam logic [15:0] SOF_W   = {K28_5, D11_5};
  localparam logic [15:0] EOF_W   = {K28_5, D21_4};

  typedef struct packed {
    logic [15:0] txd;
    logic        tkmsb;
    logic        tklsb;
    logic        enable;
    logic        loopen;
    logic        prbsen;
    logic        lckrefn;
    logic        busy;
  } pins_t;

  // Control words always carry the K flag on the upper byte only.
  function automatic pins_t kword(input pins_t p,
                                  input logic [15:0] w);
    pins_t r;
    r       = p;
    r.txd   = w;
    r.tkmsb = 1'b1;
    r.tklsb = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/tlk2711_start_edge.sv
// Start-level edge detector and launch-mode
// capture for the TLK2711 transmit framer.
module tlk2711_start_edge
  import tlk2711_pkg::*;
(
  input  logic       tx_clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [1:0] i_mode,
  input  logic       idle,
  output logic       start_edge,
  output mode_e      launch_mode
);

  logic  start_q;
  mode_e mode_q;

  assign start_edge = i_start & ~start_q;

  // The launching cycle sees i_mode directly; later cycles see the held copy.
  assign launch_mode = start_edge ? mode_e'(i_mode) : mode_q;

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      start_q <= 1'b0;
      mode_q  <= MODE_NORM;
    end else begin
      start_q <= i_start;
      if (start_edge && idle)
        mode_q <= mode_e'(i_mode);
    end
  end

endmodule

// File: rtl/tlk2711_tx_framer.sv
// TLK2711 transmit controller: framed payload with
// sync preamble, EOF marker and test modes.
module tlk2711_tx_framer
  import tlk2711_pkg::*;
#(
  parameter  int FRAME_LEN  = 32,
  parameter  int SYNC_WORDS = 2,
  localparam int LEN_W      = $clog2(FRAME_LEN + 1)
) (
  input  logic        tx_clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [1:0]  i_mode,
  input  logic [15:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [15:0] o_txd,
  output logic        o_tkmsb,
  output logic        o_tklsb,
  output logic        o_enable,
  output logic        o_loopen,
  output logic        o_prbsen,
  output logic        o_lckrefn,
  output logic        o_testen,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt
);

  localparam logic [LEN_W-1:0] PAY_LAST  = LEN_W'(FRAME_LEN - 1);
  localparam logic [3:0]       SYNC_LAST = 4'(SYNC_WORDS - 1);

  state_e           state;
  logic [LEN_W-1:0] pay_cnt;
  logic [3:0]       sync_cnt;
  logic             stop_q;
  logic             stop_req;
  logic             accept;
  logic             start_edge;
  mode_e            launch_mode;
  pins_t            nxt;
  pins_t            pins;

  tlk2711_start_edge u_start (
    .tx_clk      (tx_clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_mode      (i_mode),
    .idle        (state == ST_IDLE),
    .start_edge  (start_edge),
    .launch_mode (launch_mode)
  );

  assign s_tready = (state == ST_DATA);
  assign accept   = s_tvalid & s_tready;
  assign stop_req = stop_q | i_stop;

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pay_cnt  <= '0;
      sync_cnt <= '0;
      stop_q   <= 1'b0;
    end else begin
      if (state != ST_IDLE && i_stop)
        stop_q <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          stop_q   <= 1'b0;
          pay_cnt  <= '0;
          sync_cnt <= '0;
          if (start_edge) begin
            unique case (launch_mode)
              MODE_NORM:  state <= ST_SYNC;
              MODE_LOOP:  state <= ST_LOOP;
              MODE_KCODE: state <= ST_KCODE;
              MODE_PRBS:  state <= ST_PRBS;
              default:    state <= ST_IDLE;
            endcase
          end
        end
        ST_SYNC: begin
          if (sync_cnt == SYNC_LAST) begin
            sync_cnt <= '0;
            state    <= ST_SOF;
          end else begin
            sync_cnt <= sync_cnt + 4'd1;
          end
        end
        ST_SOF: state <= ST_DATA;
        ST_DATA: begin
          if (accept) begin
            if (pay_cnt == PAY_LAST) begin
              pay_cnt <= '0;
              state   <= ST_EOF;
            end else begin
              pay_cnt <= pay_cnt + 1'b1;
            end
          end
        end
        // A frame in flight always finishes; stop is honoured only here.
        ST_EOF: begin
          if (stop_req) begin
            stop_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            state  <= ST_SYNC;
          end
        end
        ST_LOOP, ST_KCODE, ST_PRBS: begin
          if (stop_req) begin
            stop_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    nxt = '0;
    if (state != ST_IDLE) begin
      nxt.enable  = 1'b1;
      nxt.lckrefn = 1'b1;
      nxt.busy    = 1'b1;
    end
    unique case (state)
      ST_SYNC, ST_KCODE: nxt = kword(nxt, COMMA_W);
      ST_SOF:            nxt = kword(nxt, SOF_W);
      ST_EOF:            nxt = kword(nxt, EOF_W);
      ST_LOOP: begin
        nxt        = kword(nxt, COMMA_W);
        nxt.loopen = 1'b1;
      end
      ST_DATA: begin
        if (accept)
          nxt.txd = s_tdata;
        else
          nxt = kword(nxt, COMMA_W);
      end
      ST_PRBS: nxt.prbsen = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      pins        <= '0;
      o_frame_cnt <= '0;
    end else begin
      pins <= nxt;
      if (state == ST_EOF)
        o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

  assign o_txd     = pins.txd;
  assign o_tkmsb   = pins.tkmsb;
  assign o_tklsb   = pins.tklsb;
  assign o_enable  = pins.enable;
  assign o_loopen  = pins.loopen;
  assign o_prbsen  = pins.prbsen;
  assign o_lckrefn = pins.lckrefn;
  assign o_busy    = pins.busy;
  assign o_testen  = 1'b0;

endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// Directed scoreboard bench for the TLK2711
// transmit framer (FRAME_LEN=4, SYNC_WORDS=2).
module tb_tlk2711_tx_framer;

  localparam int FL = 4;
  localparam int SW = 2;

  localparam logic [17:0] W_COMMA = {16'hBCC5, 2'b10};
  localparam logic [17:0] W_SOF   = {16'hBCAB, 2'b10};
  localparam logic [17:0] W_EOF   = {16'hBC95, 2'b10};

  logic        tx_clk;
  logic        rst;
  logic        i_start;
  logic        i_stop;
  logic [1:0]  i_mode;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] o_txd;
  logic        o_tkmsb;
  logic        o_tklsb;
  logic        o_enable;
  logic        o_loopen;
  logic        o_prbsen;
  logic        o_lckrefn;
  logic        o_testen;
  logic        o_busy;
  logic [15:0] o_frame_cnt;

  tlk2711_tx_framer #(
    .FRAME_LEN  (FL),
    .SYNC_WORDS (SW)
  ) dut (
    .tx_clk      (tx_clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_mode      (i_mode),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .o_txd       (o_txd),
    .o_tkmsb     (o_tkmsb),
    .o_tklsb     (o_tklsb),
    .o_enable    (o_enable),
    .o_loopen    (o_loopen),
    .o_prbsen    (o_prbsen),
    .o_lckrefn   (o_lckrefn),
    .o_testen    (o_testen),
    .o_busy      (o_busy),
    .o_frame_cnt (o_frame_cnt)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  int total = 0;
  int bad   = 0;

  logic [17:0] exp_q[$];
  logic [15:0] src_q[$];
  logic [17:0] mon_got;
  logic [17:0] mon_exp;
  int drv_acc   = 0;
  int frame_acc = 0;
  int gap_at    = -1;
  int gap_left  = 0;
  bit mon_en    = 1'b0;

  task automatic chk(input string tag,
                     input logic [47:0] obs,
                     input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {frame_cnt, txd, tkmsb, tklsb, enable, loopen, prbsen, lckrefn, testen, busy}
  function automatic logic [47:0] pins();
    return {8'h00, o_frame_cnt, o_txd, o_tkmsb, o_tklsb, o_enable,
            o_loopen, o_prbsen, o_lckrefn, o_testen, o_busy};
  endfunction

  function automatic logic [47:0] mk(input logic [15:0] cnt,
                                     input logic [15:0] txd,
                                     input logic [7:0]  flags);
    return {8'h00, cnt, txd, flags};
  endfunction

  task automatic push_frame(input logic [15:0] base,
                            input int gpos, input int glen);
    for (int i = 0; i < SW; i++) exp_q.push_back(W_COMMA);
    exp_q.push_back(W_SOF);
    for (int i = 0; i < FL; i++) begin
      if (i == gpos)
        for (int j = 0; j < glen; j++) exp_q.push_back(W_COMMA);
      exp_q.push_back({base + 16'(i), 2'b00});
      src_q.push_back(base + 16'(i));
    end
    exp_q.push_back(W_EOF);
  endtask

  task automatic wait_eof_then_idle(input string tag,
                                    input logic [15:0] cnt);
    int n;
    n = 0;
    while (!(o_txd == 16'hBC95 && o_tkmsb) && n < 60) begin
      @(negedge tx_clk);
      n++;
    end
    chk({tag, "_eof_seen"}, 48'(n < 60), 48'd1);
    chk({tag, "_busy_at_eof"}, 48'(o_busy), 48'd1);
    @(negedge tx_clk);
    chk({tag, "_idle_after"}, pins(), mk(cnt, 16'h0, 8'h00));
    chk({tag, "_sb_empty"}, 48'(exp_q.size()), 48'd0);
  endtask

  task automatic launch(input logic [1:0] mode);
    i_mode  = mode;
    i_start = 1'b1;
    @(negedge tx_clk);
    i_start = 1'b0;
  endtask

  // Payload source: optional gap of gap_left cycles after gap_at accepts.
  initial begin
    s_tvalid = 1'b0;
    s_tdata  = '0;
    forever begin
      @(negedge tx_clk);
      if (src_q.size() == 0) begin
        s_tvalid = 1'b0;
      end else if (s_tready && gap_left > 0 && drv_acc == gap_at) begin
        s_tvalid = 1'b0;
        gap_left--;
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = src_q[0];
      end
      #4;
      if (s_tvalid && s_tready) begin
        void'(src_q.pop_front());
        drv_acc++;
        frame_acc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge tx_clk);
      if (mon_en && o_enable) begin
        mon_got = {o_txd, o_tkmsb, o_tklsb};
        if (mon_got == W_SOF) frame_acc = 0;
        chk("sb_has_entry", 48'(exp_q.size() > 0), 48'd1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          chk("txd_word", 48'(mon_got), 48'(mon_exp));
        end
        if (mon_got == W_EOF)
          chk("accepts_per_frame", 48'(frame_acc), 48'(FL));
      end
    end
  end

  initial begin
    int n;
    rst     = 1'b1;
    i_start = 1'b0;
    i_stop  = 1'b0;
    i_mode  = 2'd0;
    repeat (3) @(negedge tx_clk);
    chk("reset_pins", pins(), mk(16'h0, 16'h0, 8'h00));
    chk("reset_tready", 48'(s_tready), 48'd0);
    rst = 1'b0;
    @(negedge tx_clk);
    chk("idle_pins", pins(), mk(16'h0, 16'h0, 8'h00));

    // Basic frame, stop latched early in SYNC.
    mon_en = 1'b1;
    push_frame(16'h0001, -1, 0);
    drv_acc = 0;
    launch(2'd0);
    i_stop = 1'b1;
    @(negedge tx_clk);
    i_stop = 1'b0;
    wait_eof_then_idle("norm", 16'd1);

    // Source starves for 3 cycles after 2 accepts; stop pulsed in DATA.
    push_frame(16'h0010, 2, 3);
    drv_acc  = 0;
    gap_at   = 2;
    gap_left = 3;
    launch(2'd0);
    repeat (3) @(negedge tx_clk);
    chk("in_data_at_stop", 48'(s_tready), 48'd1);
    i_stop = 1'b1;
    @(negedge tx_clk);
    i_stop = 1'b0;
    wait_eof_then_idle("gap", 16'd2);
    gap_at = -1;

    // Back-to-back frames without stop.
    push_frame(16'h0020, -1, 0);
    push_frame(16'h0024, -1, 0);
    drv_acc = 0;
    launch(2'd0);
    n = 0;
    while (o_frame_cnt != 16'd3 && n < 60) begin
      @(negedge tx_clk);
      n++;
    end
    chk("b2b_first_eof", 48'(o_frame_cnt), 48'd3);
    @(negedge tx_clk);
    chk("b2b_busy_after_eof", 48'(o_busy), 48'd1);
    i_stop = 1'b1;
    @(negedge tx_clk);
    i_stop = 1'b0;
    wait_eof_then_idle("b2b", 16'd4);
    mon_en = 1'b0;

    // Loopback.
    launch(2'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge tx_clk);
      chk("loop_pins", pins(), mk(16'd4, 16'hBCC5, 8'b10_1_1_0_1_0_1));
    end
    i_stop = 1'b1;
    @(negedge tx_clk);
    i_stop = 1'b0;
    @(negedge tx_clk);
    chk("loop_stopped", pins(), mk(16'd4, 16'h0, 8'h00));

    // K-code idle stream.
    launch(2'd2);
    @(negedge tx_clk);
    chk("kcode_pins", pins(), mk(16'd4, 16'hBCC5, 8'b10_1_0_0_1_0_1));
    i_stop = 1'b1;
    @(negedge tx_clk);
    i_stop = 1'b0;
    @(negedge tx_clk);
    chk("kcode_stopped", pins(), mk(16'd4, 16'h0, 8'h00));

    // PRBS, mode change and re-start ignored, then reset mid-run.
    launch(2'd3);
    @(negedge tx_clk);
    chk("prbs_pins", pins(), mk(16'd4, 16'h0, 8'b00_1_0_1_1_0_1));
    i_mode  = 2'd0;
    i_start = 1'b1;
    @(negedge tx_clk);
    i_start = 1'b0;
    @(negedge tx_clk);
    chk("prbs_hold", pins(), mk(16'd4, 16'h0, 8'b00_1_0_1_1_0_1));
    rst = 1'b1;
    @(negedge tx_clk);
    chk("prbs_rst", pins(), mk(16'h0, 16'h0, 8'h00));
    rst = 1'b0;
    @(negedge tx_clk);
    chk("post_rst_idle", pins(), mk(16'h0, 16'h0, 8'h00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
